comparator_unit: RTL and testbench



---
 rtl/comparator_unit.sv | 57 +++++
 tb/tb_comparator_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/comparator_unit.sv
// ---------------------------------------------------------------------------
// comparator_unit
//
// Registered equality / inequality comparator used by the branch logic to
// resolve beq/bne-style conditions on the 16-bit datapath.
//
// The next value of R depends only on the current A, B and mode strobes. It
// is captured on the rising clock edge, so the result appears one cycle after
// the operands are presented. There is no combinational path from any input
// to R.
//
// Ports
//   clk    in   1      system clock, rising-edge active
//   reset  in   1      asynchronous, active-high reset; clears R
//   A      in   WIDTH  first operand (raw bit pattern, unsigned)
//   B      in   WIDTH  second operand (raw bit pattern, unsigned)
//   cmpEq  in   1      request equality test
//   cmpNq  in   1      request inequality test
//   R      out  WIDTH  registered result, 0 or 1 zero-extended to WIDTH
//
// Mode strobes
//   cmpEq=0 cmpNq=0 : R <= 0 (no compare requested)
//   cmpEq=1 cmpNq=0 : R <= (A == B)
//   cmpEq=0 cmpNq=1 : R <= (A != B)
//   cmpEq=1 cmpNq=1 : R <= 1 (both terms ORed; legal, never issued on purpose)
// ---------------------------------------------------------------------------
module comparator_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cmpEq,
  input  logic             cmpNq,
  output logic [WIDTH-1:0] R
);

  logic eq;
  logic hit;

  // Full-width unsigned compare; no signed interpretation of the operands.
  assign eq  = (A == B);
  assign hit = (cmpEq & eq) | (cmpNq & ~eq);

  // The upper bits of R are constant zero, so only the LSB carries state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      R <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its inputs as they were just before the clock edge.
      R <= {{(WIDTH-1){1'b0}}, hit};
    end
  end

endmodule

// File: tb/tb_comparator_unit.sv
// ---------------------------------------------------------------------------
// tb_comparator_unit
//
// Directed bench for comparator_unit. Inputs change 1 time unit after a
// rising edge and R is sampled 1 time unit after a rising edge, well away
// from the active edge. Expected values are written out by hand.
// ---------------------------------------------------------------------------
module tb_comparator_unit;

  localparam int WIDTH = 16;
  localparam logic [WIDTH-1:0] ONE  = 16'h0001;
  localparam logic [WIDTH-1:0] ZERO = 16'h0000;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cmpEq;
  logic             cmpNq;
  logic [WIDTH-1:0] R;

  int checks = 0;
  int errors = 0;

  comparator_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .cmpEq (cmpEq),
    .cmpNq (cmpNq),
    .R     (R)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] expected);
    checks++;
    assert (R === expected) else begin
      errors++;
      $error("FAIL %s: R=0x%04h expected 0x%04h", tag, R, expected);
    end
  endtask

  initial begin
    // ---- Reset held high while the clock toggles ----
    reset = 1'b1;
    A     = 16'h0000;
    B     = 16'h0000;
    cmpEq = 1'b1;
    cmpNq = 1'b0;
    tick();
    check("reset_edge1", ZERO);
    tick();
    check("reset_edge2", ZERO);
    tick();
    check("reset_edge3", ZERO);

    // Release reset between edges; R stays 0 until the next rising edge.
    reset = 1'b0;
    #1;
    check("reset_release_hold", ZERO);
    tick();
    check("reset_first_update", ONE);

    // ---- Equality sweep ----
    cmpEq = 1'b1;
    cmpNq = 1'b0;
    for (int k = 0; k < 32; k++) begin
      A = WIDTH'(k);
      B = WIDTH'(k);
      tick();
      check($sformatf("eq_equal_k%0d", k), ONE);
      A = WIDTH'(k + 1);
      #1;
      check($sformatf("eq_hold_k%0d", k), ONE);
      tick();
      check($sformatf("eq_differ_k%0d", k), ZERO);
    end

    // ---- Inequality sweep ----
    cmpEq = 1'b0;
    cmpNq = 1'b1;
    for (int k = 0; k < 32; k++) begin
      A = WIDTH'(k + 1);
      B = WIDTH'(k);
      tick();
      check($sformatf("nq_differ_k%0d", k), ONE);
      B = WIDTH'(k + 1);
      #1;
      check($sformatf("nq_hold_k%0d", k), ONE);
      tick();
      check($sformatf("nq_equal_k%0d", k), ZERO);
    end

    // ---- Idle and both-modes ----
    A     = 16'h1234;
    B     = 16'h1235;
    cmpEq = 1'b0;
    cmpNq = 1'b0;
    tick();
    check("idle_no_mode", ZERO);
    cmpEq = 1'b1;
    cmpNq = 1'b1;
    tick();
    check("both_modes_differ", ONE);
    A = 16'hFFFF;
    B = 16'hFFFF;
    tick();
    check("both_modes_equal_ffff", ONE);
    cmpEq = 1'b0;
    cmpNq = 1'b0;
    tick();
    check("idle_equal_ffff", ZERO);

    // ---- Boundary operands ----
    cmpEq = 1'b1;
    cmpNq = 1'b0;
    A = 16'hFFFF;
    B = 16'h7FFF;
    tick();
    check("eq_msb_differs", ZERO);
    A = 16'h8001;
    B = 16'h8000;
    tick();
    check("eq_lsb_differs", ZERO);
    A = 16'h8000;
    B = 16'h8000;
    tick();
    check("eq_8000_equal", ONE);
    A = 16'h0000;
    B = 16'hFFFF;
    tick();
    check("eq_0000_vs_ffff", ZERO);
    cmpEq = 1'b0;
    cmpNq = 1'b1;
    tick();
    check("nq_0000_vs_ffff", ONE);

    // ---- Asynchronous reset mid-stream ----
    cmpEq = 1'b1;
    cmpNq = 1'b0;
    A = 16'hABCD;
    B = 16'hABCD;
    tick();
    check("async_pre_true", ONE);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_immediate", ZERO);
    reset = 1'b0;
    #1;
    check("async_release_hold", ZERO);
    tick();
    check("async_restore", ONE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
